// File: rtl/fifo_round_robin_pkg.sv
`default_nettype none
// ============================================================================
// Module      : fifo_round_robin_pkg
// Description : Shared types and helpers for the lane-interleaved FIFO.
// Revision    : 1.0 - initial release
// ============================================================================
package fifo_round_robin_pkg;

   // Largest supported lane count; lane indices are sized to cover it.
   localparam int c_MAX_LANES = 16;

   // Lane index wide enough for any legal LANES value.
   typedef logic [3:0] lane_idx_t;

   // Width of an occupancy counter able to hold 0..lanes*depth.
   function automatic int count_width(input int lanes, input int depth);
      return $clog2(lanes * depth + 1);
   endfunction

endpackage : fifo_round_robin_pkg
`default_nettype wire

// File: rtl/fifo_lane.sv
`default_nettype none
// ============================================================================
// Module      : fifo_lane
// Description : Single circular-buffer lane with full/empty flags and head
//               output. Cleared by asynchronous reset or synchronous flush.
// Revision    : 1.0 - initial release
// ============================================================================
module fifo_lane #(
   parameter int WIDTH = 96,
   parameter int DEPTH = 2
) (
   input  logic             CLK,
   input  logic             RST,
   input  logic             flush,
   input  logic             wr_en,
   input  logic [WIDTH-1:0] wr_data,
   input  logic             rd_en,
   output logic             full,
   output logic             empty,
   output logic [WIDTH-1:0] head
);

   localparam int c_PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int c_CW = $clog2(DEPTH + 1);
   localparam logic [c_PW-1:0] c_LAST = c_PW'(DEPTH - 1);
   localparam logic [c_CW-1:0] c_FULL = c_CW'(DEPTH);

   // Storage is rounded up to a power of two so every pointer value indexes a
   // real entry; pointers still wrap at DEPTH-1.
   logic [WIDTH-1:0] r_mem [2**c_PW];
   logic [c_PW-1:0]  r_wr_ptr;
   logic [c_PW-1:0]  r_rd_ptr;
   logic [c_CW-1:0]  r_cnt;
   logic             w_wr;
   logic             w_rd;

   assign full  = (r_cnt == c_FULL);
   assign empty = (r_cnt == '0);
   assign head  = r_mem[r_rd_ptr];
   assign w_wr  = wr_en && !full;
   assign w_rd  = rd_en && !empty;

   // Data array: written on accepted pushes only, never reset.
   always_ff @(posedge CLK) begin
      if (w_wr && !flush) begin
         r_mem[r_wr_ptr] <= wr_data;
      end
   end

   // Pointers and occupancy; flush and reset both discard all entries.
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_cnt    <= '0;
      end else if (flush) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_cnt    <= '0;
      end else begin
         if (w_wr) begin
            r_wr_ptr <= (r_wr_ptr == c_LAST) ? '0 : r_wr_ptr + c_PW'(1);
         end
         if (w_rd) begin
            r_rd_ptr <= (r_rd_ptr == c_LAST) ? '0 : r_rd_ptr + c_PW'(1);
         end
         if (w_wr && !w_rd) begin
            r_cnt <= r_cnt + c_CW'(1);
         end else if (w_rd && !w_wr) begin
            r_cnt <= r_cnt - c_CW'(1);
         end
      end
   end

endmodule : fifo_lane
`default_nettype wire

// File: rtl/fifo_round_robin.sv
`default_nettype none
// ============================================================================
// Module      : fifo_round_robin
// Description : FIFO built from LANES interleaved lanes. Writes and reads
//               rotate across lanes, so overall order is preserved while
//               each lane only sees every LANES-th entry.
// Revision    : 1.0 - initial release
// ============================================================================
module fifo_round_robin
   import fifo_round_robin_pkg::*;
#(
   parameter int WIDTH = 96,
   parameter int LANES = 4,
   parameter int DEPTH = 2
) (
   input  logic                                   CLK,
   input  logic                                   RST,
   input  logic [WIDTH-1:0]                       enq_v,
   input  logic                                   enq__ENA,
   output logic                                   enq__RDY,
   output logic [WIDTH-1:0]                       first,
   output logic                                   first__RDY,
   input  logic                                   deq__ENA,
   output logic                                   deq__RDY,
   input  logic                                   flush,
   output logic [count_width(LANES, DEPTH)-1:0]   count
);

   localparam int        c_CW   = count_width(LANES, DEPTH);
   localparam lane_idx_t c_LAST = lane_idx_t'(LANES - 1);

   lane_idx_t        r_wp;
   lane_idx_t        r_rp;
   logic [c_CW-1:0]  r_count;

   // Per-lane status, padded to the maximum lane count so a lane index can
   // select directly; padding lanes look permanently full and empty.
   logic [c_MAX_LANES-1:0] w_full;
   logic [c_MAX_LANES-1:0] w_empty;
   logic [WIDTH-1:0]       w_head [c_MAX_LANES];

   logic w_deq_ok;
   logic w_enq_fire;
   logic w_deq_fire;

   assign enq__RDY   = !flush && !w_full[r_wp];
   assign w_deq_ok   = !flush && !w_empty[r_rp];
   assign deq__RDY   = w_deq_ok;
   assign first__RDY = w_deq_ok;
   assign first      = w_deq_ok ? w_head[r_rp] : '0;
   assign w_enq_fire = enq__ENA && enq__RDY;
   assign w_deq_fire = deq__ENA && w_deq_ok;
   assign count      = r_count;

   generate
      for (genvar g = 0; g < c_MAX_LANES; g++) begin : g_lane
         if (g < LANES) begin : g_real
            fifo_lane #(
               .WIDTH (WIDTH),
               .DEPTH (DEPTH)
            ) u_lane (
               .CLK     (CLK),
               .RST     (RST),
               .flush   (flush),
               .wr_en   (w_enq_fire && (r_wp == lane_idx_t'(g))),
               .wr_data (enq_v),
               .rd_en   (w_deq_fire && (r_rp == lane_idx_t'(g))),
               .full    (w_full[g]),
               .empty   (w_empty[g]),
               .head    (w_head[g])
            );
         end else begin : g_pad
            assign w_full[g]  = 1'b1;
            assign w_empty[g] = 1'b1;
            assign w_head[g]  = '0;
         end
      end
   endgenerate

   // Lane pointers rotate on each accepted transfer; flush rewinds to lane 0.
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         r_wp <= '0;
         r_rp <= '0;
      end else if (flush) begin
         r_wp <= '0;
         r_rp <= '0;
      end else begin
         if (w_enq_fire) begin
            r_wp <= (r_wp == c_LAST) ? '0 : r_wp + 4'd1;
         end
         if (w_deq_fire) begin
            r_rp <= (r_rp == c_LAST) ? '0 : r_rp + 4'd1;
         end
      end
   end

   // Total occupancy: up on push-only, down on pop-only, hold otherwise.
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         r_count <= '0;
      end else if (flush) begin
         r_count <= '0;
      end else if (w_enq_fire && !w_deq_fire) begin
         r_count <= r_count + c_CW'(1);
      end else if (w_deq_fire && !w_enq_fire) begin
         r_count <= r_count - c_CW'(1);
      end
   end

endmodule : fifo_round_robin
`default_nettype wire

// File: tb/tb_fifo_round_robin.sv
`default_nettype none
// ============================================================================
// Module      : tb_fifo_round_robin
// Description : Directed and randomised self-checking bench for
//               fifo_round_robin (WIDTH=8, LANES=3, DEPTH=2).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fifo_round_robin;

   logic       CLK;
   logic       RST;
   logic [7:0] enq_v;
   logic       enq__ENA;
   logic       enq__RDY;
   logic [7:0] first;
   logic       first__RDY;
   logic       deq__ENA;
   logic       deq__RDY;
   logic       flush;
   logic [2:0] count;

   int checks = 0;
   int errors = 0;
   int printed = 0;

   fifo_round_robin #(
      .WIDTH (8),
      .LANES (3),
      .DEPTH (2)
   ) dut (
      .CLK        (CLK),
      .RST        (RST),
      .enq_v      (enq_v),
      .enq__ENA   (enq__ENA),
      .enq__RDY   (enq__RDY),
      .first      (first),
      .first__RDY (first__RDY),
      .deq__ENA   (deq__ENA),
      .deq__RDY   (deq__RDY),
      .flush      (flush),
      .count      (count)
   );

   initial begin
      CLK = 1'b0;
      forever #5 CLK = ~CLK;
   end

   // Advance to just after the next rising edge.
   task automatic step();
      @(posedge CLK);
      #1;
   endtask

   task automatic do_reset();
      RST = 1'b1;
      enq__ENA = 1'b0;
      deq__ENA = 1'b0;
      flush = 1'b0;
      enq_v = 8'h00;
      repeat (2) @(posedge CLK);
      #1;
      RST = 1'b0;
      #1;
   endtask

   task automatic test_reset();
      do_reset();
      checks++;
      if (enq__RDY !== 1'b1 || first__RDY !== 1'b0 || deq__RDY !== 1'b0 ||
          first !== 8'h00 || count !== 3'd0) begin
         errors++;
         $display("FAIL reset: enq_rdy=%b first_rdy=%b deq_rdy=%b first=%h count=%0d, want 1 0 0 00 0",
                  enq__RDY, first__RDY, deq__RDY, first, count);
      end
   endtask

   task automatic test_back_to_back();
      logic [7:0] vals [4];
      vals = '{8'h11, 8'h22, 8'h33, 8'h44};
      do_reset();
      for (int i = 0; i < 4; i++) begin
         enq_v = vals[i];
         enq__ENA = 1'b1;
         #1;
         checks++;
         if (enq__RDY !== 1'b1) begin
            errors++;
            $display("FAIL b2b_enq_rdy[%0d]: got %b want 1", i, enq__RDY);
         end
         if (i == 0) begin
            checks++;
            if (first__RDY !== 1'b0) begin
               errors++;
               $display("FAIL b2b_no_bypass: first_rdy=%b want 0", first__RDY);
            end
         end
         if (i == 1) begin
            checks++;
            if (first__RDY !== 1'b1 || first !== 8'h11) begin
               errors++;
               $display("FAIL b2b_first_latency: first_rdy=%b first=%h want 1 11", first__RDY, first);
            end
         end
         step();
      end
      enq__ENA = 1'b0;
      #1;
      checks++;
      if (count !== 3'd4 || first !== 8'h11) begin
         errors++;
         $display("FAIL b2b_count: count=%0d first=%h want 4 11", count, first);
      end
      // Drain and confirm order.
      for (int i = 0; i < 4; i++) begin
         deq__ENA = 1'b1;
         #1;
         checks++;
         if (deq__RDY !== 1'b1 || first !== vals[i]) begin
            errors++;
            $display("FAIL b2b_drain[%0d]: rdy=%b first=%h want 1 %h", i, deq__RDY, first, vals[i]);
         end
         step();
      end
      deq__ENA = 1'b0;
   endtask

   task automatic test_full();
      do_reset();
      for (int i = 0; i < 6; i++) begin
         enq_v = 8'hA0 + 8'(i);
         enq__ENA = 1'b1;
         #1;
         checks++;
         if (enq__RDY !== 1'b1) begin
            errors++;
            $display("FAIL full_enq_rdy[%0d]: got %b want 1", i, enq__RDY);
         end
         step();
      end
      enq_v = 8'hA6;
      #1;
      checks++;
      if (enq__RDY !== 1'b0) begin
         errors++;
         $display("FAIL full_7th_rdy: got %b want 0", enq__RDY);
      end
      step();
      enq__ENA = 1'b0;
      #1;
      checks++;
      if (count !== 3'd6) begin
         errors++;
         $display("FAIL full_count: got %0d want 6", count);
      end
      for (int i = 0; i < 6; i++) begin
         deq__ENA = 1'b1;
         #1;
         checks++;
         if (deq__RDY !== 1'b1 || first !== 8'hA0 + 8'(i)) begin
            errors++;
            $display("FAIL full_order[%0d]: rdy=%b first=%h want 1 %h", i, deq__RDY, first, 8'hA0 + 8'(i));
         end
         step();
      end
      deq__ENA = 1'b0;
      #1;
      checks++;
      if (first__RDY !== 1'b0 || first !== 8'h00 || count !== 3'd0 ||
          dut.r_wp !== 4'd0 || dut.r_rp !== 4'd0) begin
         errors++;
         $display("FAIL full_empty_after: first_rdy=%b first=%h count=%0d wp=%0d rp=%0d want 0 00 0 0 0",
                  first__RDY, first, count, dut.r_wp, dut.r_rp);
      end
   endtask

   task automatic test_steady();
      do_reset();
      enq_v = 8'h40;
      enq__ENA = 1'b1;
      step();
      for (int i = 0; i < 50; i++) begin
         enq_v = 8'h41 + 8'(i);
         enq__ENA = 1'b1;
         deq__ENA = 1'b1;
         #1;
         checks++;
         if (count !== 3'd1 || first__RDY !== 1'b1 || enq__RDY !== 1'b1 ||
             first !== 8'h40 + 8'(i)) begin
            errors++;
            $display("FAIL steady[%0d]: count=%0d rdy=%b/%b first=%h want 1 1/1 %h",
                     i, count, first__RDY, enq__RDY, first, 8'h40 + 8'(i));
         end
         step();
      end
      enq__ENA = 1'b0;
      deq__ENA = 1'b0;
      #1;
      // 51 pushes and 50 pops over three lanes.
      checks++;
      if (count !== 3'd1 || first !== 8'h72 || dut.r_wp !== 4'd0 || dut.r_rp !== 4'd2) begin
         errors++;
         $display("FAIL steady_end: count=%0d first=%h wp=%0d rp=%0d want 1 72 0 2",
                  count, first, dut.r_wp, dut.r_rp);
      end
   endtask

   task automatic test_flush();
      do_reset();
      for (int i = 0; i < 4; i++) begin
         enq_v = 8'h01 + 8'(i);
         enq__ENA = 1'b1;
         step();
      end
      flush = 1'b1;
      enq_v = 8'h99;
      enq__ENA = 1'b1;
      #1;
      checks++;
      if (enq__RDY !== 1'b0 || deq__RDY !== 1'b0 || first__RDY !== 1'b0) begin
         errors++;
         $display("FAIL flush_rdy_block: enq=%b deq=%b first=%b want 0 0 0", enq__RDY, deq__RDY, first__RDY);
      end
      step();
      flush = 1'b0;
      enq__ENA = 1'b0;
      #1;
      checks++;
      if (count !== 3'd0 || first__RDY !== 1'b0) begin
         errors++;
         $display("FAIL flush_empty: count=%0d first_rdy=%b want 0 0", count, first__RDY);
      end
      enq_v = 8'h55;
      enq__ENA = 1'b1;
      step();
      enq__ENA = 1'b0;
      #1;
      checks++;
      if (first__RDY !== 1'b1 || first !== 8'h55 || dut.r_wp !== 4'd1 || count !== 3'd1) begin
         errors++;
         $display("FAIL flush_next_enq: first_rdy=%b first=%h wp=%0d count=%0d want 1 55 1 1",
                  first__RDY, first, dut.r_wp, count);
      end
   endtask

   task automatic test_async_reset();
      do_reset();
      for (int i = 0; i < 3; i++) begin
         enq_v = 8'hE0 + 8'(i);
         enq__ENA = 1'b1;
         step();
      end
      enq__ENA = 1'b0;
      #3;
      RST = 1'b1;
      #1;
      checks++;
      if (first__RDY !== 1'b0 || count !== 3'd0) begin
         errors++;
         $display("FAIL async_reset: first_rdy=%b count=%0d want 0 0", first__RDY, count);
      end
      #1;
      RST = 1'b0;
      step();
      enq_v = 8'h77;
      enq__ENA = 1'b1;
      step();
      enq__ENA = 1'b0;
      deq__ENA = 1'b1;
      #1;
      checks++;
      if (deq__RDY !== 1'b1 || first !== 8'h77) begin
         errors++;
         $display("FAIL async_reset_reuse: rdy=%b first=%h want 1 77", deq__RDY, first);
      end
      step();
      deq__ENA = 1'b0;
      #1;
      checks++;
      if (first__RDY !== 1'b0 || count !== 3'd0) begin
         errors++;
         $display("FAIL async_reset_drain: first_rdy=%b count=%0d want 0 0", first__RDY, count);
      end
   endtask

   task automatic test_random();
      logic [7:0] sb [$];
      int         lc [3];
      int         mwp;
      int         mrp;
      bit         e;
      bit         d;
      bit         er;
      bit         dr;
      logic [7:0] v;
      do_reset();
      lc = '{0, 0, 0};
      mwp = 0;
      mrp = 0;
      for (int n = 0; n < 10000; n++) begin
         e = 1'($urandom_range(0, 1));
         d = 1'($urandom_range(0, 1));
         v = 8'($urandom_range(0, 255));
         enq_v = v;
         enq__ENA = e;
         deq__ENA = d;
         er = (lc[mwp] < 2);
         dr = (lc[mrp] > 0);
         #1;
         checks++;
         if (enq__RDY !== er || deq__RDY !== dr || first__RDY !== dr ||
             count !== 3'(sb.size())) begin
            errors++;
            if (printed < 20) begin
               printed++;
               $display("FAIL rand_ctl[%0d]: enq_rdy=%b deq_rdy=%b first_rdy=%b count=%0d want %b %b %b %0d",
                        n, enq__RDY, deq__RDY, first__RDY, count, er, dr, dr, sb.size());
            end
         end
         if (dr) begin
            checks++;
            if (first !== sb[0]) begin
               errors++;
               if (printed < 20) begin
                  printed++;
                  $display("FAIL rand_data[%0d]: first=%h want %h", n, first, sb[0]);
               end
            end
         end
         step();
         if (e && er) begin
            sb.push_back(v);
            lc[mwp]++;
            mwp = (mwp + 1) % 3;
         end
         if (d && dr) begin
            void'(sb.pop_front());
            lc[mrp]--;
            mrp = (mrp + 1) % 3;
         end
      end
      enq__ENA = 1'b0;
      deq__ENA = 1'b0;
   endtask

   initial begin
      RST = 1'b1;
      enq__ENA = 1'b0;
      deq__ENA = 1'b0;
      flush = 1'b0;
      enq_v = 8'h00;
      test_reset();
      test_back_to_back();
      test_full();
      test_steady();
      test_flush();
      test_async_reset();
      test_random();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule : tb_fifo_round_robin
`default_nettype wire
